bbc_slowbus_ctrl: RTL

BBC_SLOWBUS_CTRL -- requirements
Module: bbc_slowbus_ctrl

---
 rtl/bbc_slowbus_ctrl_pkg.sv | 21 ++
 rtl/phi0_sync.sv | 38 +++
 rtl/bbc_slowbus_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bbc_slowbus_ctrl_pkg.sv
// Shared types and defaults for the BBC slow-bus controller.
// States follow the BBC phi0 phases; the timer width bounds TIMEOUT to 8 bits.
package bbc_slowbus_ctrl_pkg;

  localparam int          DEF_SYNC_STAGES = 2;
  localparam int          DEF_TIMEOUT     = 255;
  localparam logic [15:0] BUS_IDLE_ADDR   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_PHI1  = 3'd2,
    ST_PHI2  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic in_access(input state_t s);
    return (s == ST_ALIGN) || (s == ST_PHI1) || (s == ST_PHI2);
  endfunction

endpackage

// File: rtl/phi0_sync.sv
// Synchronises bbc_ck2_phi0 into hsclk and flags its edges.
// Edge pulses appear SYNC_STAGES cycles after the raw edge; no backpressure.
module phi0_sync
  import bbc_slowbus_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic hsclk,
  input  logic resetb,
  input  logic phi0_async,
  output logic phi0_s1,
  output logic rise_s,
  output logic fall_s
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;
  logic         phi0_s;

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], phi0_async};
      prev_q <= sync_q[N-1];
    end
  end

  // Stage 1 is exported for read capture: it tracks phi0 one cycle ahead of phi0_s.
  assign phi0_s1 = sync_q[0];
  assign phi0_s  = sync_q[N-1];
  assign rise_s  = phi0_s & ~prev_q;
  assign fall_s  = ~phi0_s & prev_q;

endmodule

// File: rtl/bbc_slowbus_ctrl.sv
// Runs one BBC bus cycle per CPU request, aligned to a full phi0 period.
// Latency: wait for phi0 fall + phi1 + phi2 + 1; stalls the CPU via cpu_rdy until ack.
module bbc_slowbus_ctrl
  import bbc_slowbus_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        hsclk,
  input  logic        resetb,
  input  logic        bbc_ck2_phi0,
  input  logic        req,
  input  logic        req_rnw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  bbc_rdata,
  output logic        cpu_rdy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] bbc_addr,
  output logic        bbc_rnw,
  output logic [7:0]  bbc_wdata,
  output logic        bbc_data_oe
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  timer_q;
  logic [15:0] addr_q;
  logic        rnw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        to_err;
  logic        phi0_s1, rise_s, fall_s;
  logic        accept;
  logic        tmo_hit;

  phi0_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_phi0_sync (
    .hsclk      (hsclk),
    .resetb     (resetb),
    .phi0_async (bbc_ck2_phi0),
    .phi0_s1    (phi0_s1),
    .rise_s     (rise_s),
    .fall_s     (fall_s)
  );

  assign accept  = (state_q == ST_IDLE) && req;
  assign tmo_hit = (timer_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    to_err  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (req) state_d = ST_ALIGN;
      ST_ALIGN: begin
        if (tmo_hit) begin
          state_d = ST_DONE;
          to_err  = 1'b1;
        end else if (fall_s) begin
          state_d = ST_PHI1;
        end
      end
      ST_PHI1: begin
        if (tmo_hit) begin
          state_d = ST_DONE;
          to_err  = 1'b1;
        end else if (rise_s) begin
          state_d = ST_PHI2;
        end
      end
      // A phi0 fall landing on the last timer cycle still completes the access cleanly.
      ST_PHI2: begin
        if (fall_s) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          to_err  = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      addr_q  <= BUS_IDLE_ADDR;
      rnw_q   <= 1'b1;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= to_err;
      if (accept) begin
        timer_q <= 8'd0;
        addr_q  <= req_addr;
        rnw_q   <= req_rnw;
        wdata_q <= req_wdata;
      end else if (in_access(state_q)) begin
        timer_q <= timer_q + 8'd1;
      end
      if ((state_q == ST_PHI2) && phi0_s1) begin
        rdata_q <= bbc_rdata;
      end
    end
  end

  // Bus outputs decode straight from the state register so reset parks them at once.
  assign ack         = (state_q == ST_DONE);
  assign err         = ack & err_q;
  assign cpu_rdy     = ~(req & (state_q != ST_DONE));
  assign rdata       = rdata_q;
  assign bbc_addr    = (state_q == ST_IDLE) ? BUS_IDLE_ADDR : addr_q;
  assign bbc_rnw     = (state_q == ST_IDLE) | rnw_q;
  assign bbc_wdata   = wdata_q;
  assign bbc_data_oe = (state_q == ST_PHI2) & ~rnw_q;

endmodule
